// File: rtl/jt49_wrq_pkg.sv
// jt49_wrq_pkg: shared types and constants for the JT49 register-write queue.
// Revision 1.0 - initial release
`default_nettype none

package jt49_wrq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WSETUP  = 3'd1,
      ST_WSTROBE = 3'd2,
      ST_WHOLD   = 3'd3,
      ST_RSETUP  = 3'd4,
      ST_RWAIT   = 3'd5
   } state_t;

   // Writing the envelope shape register restarts the envelope, so it is never deduplicated
   localparam logic [3:0] ENV_REG = 4'hD;

   localparam int DATA_LSB = 0;
   localparam int ADDR_LSB = 8;
   localparam int RD_BIT   = 12;
   localparam int ENTRY_W  = 13;

   typedef struct packed {
      logic       rd;
      logic [3:0] addr;
      logic [7:0] data;
   } entry_t;

endpackage

`default_nettype wire

// File: rtl/jt49_wrq_fifo.sv
// jt49_wrq_fifo: synchronous FIFO of 2**AW entries with occupancy level and full/empty flags.
// Revision 1.0 - initial release
`default_nettype none

module jt49_wrq_fifo #(
   parameter int AW = 4,
   parameter int DW = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   // Full blocks a push even when a pop happens in the same cycle
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

`default_nettype wire

// File: rtl/jt49_wrq.sv
// jt49_wrq: queues register requests and replays them as jt49 bus cycles.
// Optional write deduplication shadow enabled by defining JT49_WRQ_DEDUP_EN. Revision 1.0
`default_nettype none

module jt49_wrq #(
   parameter int AW     = 4,
   parameter int WR_CYC = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_rd,
   input  logic [3:0]    req_addr,
   input  logic [7:0]    req_data,
   output logic          rd_valid,
   output logic [7:0]    rd_data,
   output logic          busy,
   output logic [AW:0]   fifo_level,
   output logic [3:0]    psg_addr,
   output logic          psg_cs_n,
   output logic          psg_wr_n,
   output logic [7:0]    psg_din,
   input  logic [7:0]    psg_dout
);

   import jt49_wrq_pkg::*;

   state_t             state;
   logic [3:0]         strobe_cnt;
   logic [ENTRY_W-1:0] head_bits;
   entry_t             head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               drop;

   assign head      = head_bits;
   assign req_ready = ~fifo_full;
   assign pop       = (state == ST_IDLE) && !fifo_empty;
   assign busy      = !fifo_empty || (state != ST_IDLE);

   jt49_wrq_fifo #(
      .AW (AW),
      .DW (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid),
      .wdata ({req_rd, req_addr, req_data}),
      .pop   (pop),
      .rdata (head_bits),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef JT49_WRQ_DEDUP_EN
   logic [7:0]  shadow [16];
   logic [15:0] shadow_vld;
   logic        issue_wr;

   assign drop     = !head.rd && (head.addr != ENV_REG) && shadow_vld[head.addr]
                     && (shadow[head.addr] == head.data);
   assign issue_wr = pop && !head.rd && !drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_vld <= '0;
      end else if (issue_wr) begin
         shadow_vld[head.addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (issue_wr) begin
         shadow[head.addr] <= head.data;
      end
   end
`else
   assign drop = 1'b0;
`endif

   // Bus outputs change together with the state so each state's bus levels are registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         strobe_cnt <= '0;
         psg_cs_n   <= 1'b1;
         psg_wr_n   <= 1'b1;
         psg_addr   <= '0;
         psg_din    <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  if (head.rd) begin
                     state    <= ST_RSETUP;
                     psg_cs_n <= 1'b0;
                     psg_addr <= head.addr;
                  end else if (!drop) begin
                     state    <= ST_WSETUP;
                     psg_cs_n <= 1'b0;
                     psg_addr <= head.addr;
                     psg_din  <= head.data;
                  end
               end
            end
            ST_WSETUP: begin
               state      <= ST_WSTROBE;
               psg_wr_n   <= 1'b0;
               strobe_cnt <= 4'(WR_CYC - 1);
            end
            ST_WSTROBE: begin
               if (strobe_cnt == '0) begin
                  state    <= ST_WHOLD;
                  psg_wr_n <= 1'b1;
               end else begin
                  strobe_cnt <= strobe_cnt - 1'b1;
               end
            end
            ST_WHOLD: begin
               state    <= ST_IDLE;
               psg_cs_n <= 1'b1;
            end
            ST_RSETUP: begin
               state <= ST_RWAIT;
            end
            ST_RWAIT: begin
               state    <= ST_IDLE;
               psg_cs_n <= 1'b1;
               rd_data  <= psg_dout;
               rd_valid <= 1'b1;
            end
            default: begin
               state    <= ST_IDLE;
               psg_cs_n <= 1'b1;
               psg_wr_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jt49_wrq.sv
// tb_jt49_wrq: self-checking bench for jt49_wrq with a behavioural jt49 register-bus model.
// Revision 1.0 - initial release
`default_nettype none

module tb_jt49_wrq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rd = 1'b0;
   logic [3:0] req_addr = '0;
   logic [7:0] req_data = '0;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       busy;
   logic [4:0] fifo_level;
   logic [3:0] psg_addr;
   logic       psg_cs_n;
   logic       psg_wr_n;
   logic [7:0] psg_din;
   logic [7:0] psg_dout = '0;

   int checks = 0;
   int errors = 0;

   jt49_wrq #(.AW(4), .WR_CYC(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rd     (req_rd),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .busy       (busy),
      .fifo_level (fifo_level),
      .psg_addr   (psg_addr),
      .psg_cs_n   (psg_cs_n),
      .psg_wr_n   (psg_wr_n),
      .psg_din    (psg_din),
      .psg_dout   (psg_dout)
   );

   always #5 clk = ~clk;

   // jt49 bus model
   logic [7:0]  regs [16];
   logic [11:0] wlog [$];
   int   n_wr = 0, n_env = 0, stab_err = 0, rdv_cnt = 0, rdv_double = 0;
   int   ready_err = 0;
   logic full_seen = 1'b0;
   logic prev_wr = 1'b1, prev_cs = 1'b1, prev_rdv = 1'b0;
   logic [3:0] prev_addr = '0;
   logic [7:0] prev_din = '0;

   function automatic logic [7:0] jt_mask(input logic [3:0] a);
      case (a)
         4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
         default:                 return 8'hFF;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regs[i] = 8'h00;
      end else begin
         if (!psg_cs_n && !prev_cs && (psg_addr != prev_addr || psg_din != prev_din))
            stab_err++;
         if (!psg_cs_n && !psg_wr_n && prev_wr) begin
            regs[psg_addr] = psg_din & jt_mask(psg_addr);
            n_wr++;
            if (psg_addr == 4'd13) n_env++;
            wlog.push_back({psg_addr, psg_din});
         end
         if (rd_valid) begin
            rdv_cnt++;
            if (prev_rdv) rdv_double++;
         end
         if (!req_ready) begin
            full_seen = 1'b1;
            if (fifo_level != 5'd16) ready_err++;
         end
      end
      psg_dout  = regs[psg_addr];
      prev_wr   = psg_wr_n;
      prev_cs   = psg_cs_n;
      prev_addr = psg_addr;
      prev_din  = psg_din;
      prev_rdv  = rd_valid;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the request was accepted
   task automatic push(input logic rd, input logic [3:0] a, input logic [7:0] d);
      int guard;
      req_valid = 1'b1;
      req_rd    = rd;
      req_addr  = a;
      req_data  = d;
      guard     = 0;
      while (!req_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 500) begin
            chk("push_timeout", 1, 0);
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (busy) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            chk("idle_timeout", 1, 0);
            break;
         end
      end
   endtask

   typedef struct {
      logic       rd;
      logic [3:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [5:0] seq_cs;
      logic [5:0] seq_wr;
      logic [3:0] strobe_addr;
      logic [7:0] strobe_din;
      int base_wr, base_env, base_rdv, order_err, guard;
      int exp_dedup;

      tbl[0] = '{1'b0, 4'd7, 8'h3F, 8'h3F};
      tbl[1] = '{1'b0, 4'd1, 8'h5A, 8'h0A};
      tbl[2] = '{1'b1, 4'd1, 8'h00, 8'h0A};
      tbl[3] = '{1'b0, 4'd8, 8'hFF, 8'h1F};
      tbl[4] = '{1'b1, 4'd8, 8'h00, 8'h1F};
      tbl[5] = '{1'b0, 4'd2, 8'hA5, 8'hA5};
      tbl[6] = '{1'b1, 4'd2, 8'h00, 8'hA5};
      tbl[7] = '{1'b1, 4'd7, 8'h00, 8'h3F};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cs_n", psg_cs_n, 1);
      chk("rst_wr_n", psg_wr_n, 1);
      chk("rst_addr", psg_addr, 0);
      chk("rst_din", psg_din, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", req_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      // Single write bus-cycle shape: IDLE, WSETUP, WSTROBE, WHOLD, IDLE, IDLE
      push(1'b0, 4'd7, 8'h38);
      req_valid = 1'b0;
      chk("wr_level_after_push", fifo_level, 1);
      chk("wr_busy_after_push", busy, 1);
      seq_cs = '0;
      seq_wr = '0;
      strobe_addr = '0;
      strobe_din = '0;
      for (int i = 0; i < 6; i++) begin
         seq_cs = {seq_cs[4:0], psg_cs_n};
         seq_wr = {seq_wr[4:0], psg_wr_n};
         if (!psg_wr_n) begin
            strobe_addr = psg_addr;
            strobe_din  = psg_din;
         end
         @(negedge clk);
      end
      chk("wr_cs_n_seq", seq_cs, 6'b100011);
      chk("wr_wr_n_seq", seq_wr, 6'b110111);
      chk("wr_strobe_addr", strobe_addr, 7);
      chk("wr_strobe_din", strobe_din, 8'h38);
      chk("wr_model_reg7", regs[7], 8'h38);

      // Table of writes and reads
      for (int i = 0; i < 8; i++) begin
         base_rdv = rdv_cnt;
         push(tbl[i].rd, tbl[i].addr, tbl[i].data);
         req_valid = 1'b0;
         wait_idle();
         repeat (2) @(negedge clk);
         if (tbl[i].rd) begin
            chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].exp);
            chk($sformatf("tbl%0d_rd_pulses", i), rdv_cnt - base_rdv, 1);
            chk($sformatf("tbl%0d_rd_valid_low", i), rd_valid, 0);
         end else begin
            chk($sformatf("tbl%0d_model_reg", i), regs[tbl[i].addr], tbl[i].exp);
         end
      end

      // Back-pressure: 24 streamed writes fill the 16-entry FIFO
      wlog.delete();
      for (int i = 0; i < 24; i++) push(1'b0, 4'(i % 12), 8'(i * 7 + 1));
      req_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      chk("bp_full_seen", full_seen, 1);
      chk("bp_ready_low_not_full", ready_err, 0);
      chk("bp_write_count", wlog.size(), 24);
      order_err = 0;
      for (int i = 0; i < 24; i++) begin
         if (i >= wlog.size() || wlog[i] != {4'(i % 12), 8'(i * 7 + 1)}) order_err++;
      end
      chk("bp_order_errors", order_err, 0);
      chk("bp_level_drained", fifo_level, 0);

      // Envelope restart: reg13 written twice always gives two strobes
      base_env = n_env;
      base_wr  = n_wr;
      push(1'b0, 4'd13, 8'h0E);
      push(1'b0, 4'd13, 8'h0E);
      req_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      chk("env_restarts", n_env - base_env, 2);
      chk("env_writes", n_wr - base_wr, 2);
      chk("env_model_reg13", regs[13], 8'h0E);

      // Duplicate write to a non-envelope register
`ifdef JT49_WRQ_DEDUP_EN
      exp_dedup = 1;
`else
      exp_dedup = 2;
`endif
      base_wr = n_wr;
      push(1'b0, 4'd0, 8'h12);
      push(1'b0, 4'd0, 8'h12);
      req_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      chk("dup_writes", n_wr - base_wr, exp_dedup);
      base_wr = n_wr;
      push(1'b0, 4'd0, 8'h13);
      req_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      chk("dup_new_value_writes", n_wr - base_wr, 1);
      chk("dup_model_reg0", regs[0], 8'h13);

      // Asynchronous reset in the middle of a strobe with entries still queued
      push(1'b0, 4'd3, 8'h05);
      push(1'b0, 4'd4, 8'h11);
      push(1'b0, 4'd5, 8'h22);
      req_valid = 1'b0;
      guard = 0;
      while (psg_wr_n && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("ar_strobe_reached", psg_wr_n, 0);
      rst = 1'b1;
      #1;
      chk("ar_cs_n", psg_cs_n, 1);
      chk("ar_wr_n", psg_wr_n, 1);
      chk("ar_level", fifo_level, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ready", req_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push(1'b0, 4'd3, 8'h07);
      req_valid = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      chk("ar_post_write_reg3", regs[3], 8'h07);
      chk("ar_flushed_reg4", regs[4], 8'h00);
      chk("ar_flushed_reg5", regs[5], 8'h00);

      chk("bus_addr_din_stability", stab_err, 0);
      chk("rd_valid_single_cycle", rdv_double, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
